block_config_loader: RTL and testbench
======================================

BLOCK_CONFIG_LOADER -- requirements
Module: block_config_loader

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4, number of config latch blocks sequenced.
REQ-002 SHALL have parameter MEM_SIZE, default 16, config bits per latch block.
REQ-003 SHALL have parameter IDX_BITS, default $clog2(NUM_BLOCKS), block index width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a full configuration pass.
REQ-007 SHALL have port cfg_bit  input  1  serial config data, MSB of block 0 first.
REQ-008 SHALL have port cfg_valid  input  1  cfg_bit valid this cycle.
REQ-009 SHALL have port cfg_ready  output  1  loader accepts cfg_bit this cycle.
REQ-010 SHALL have port config_in  output  MEM_SIZE  parallel word to all latch blocks.
REQ-011 SHALL have port comb_set  output  NUM_BLOCKS  one-hot latch enable, one bit per block.
REQ-012 SHALL have port busy  output  1  pass in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of pass.

Function
REQ-014 SHALL implement states IDLE, SHIFT, SETUP, STROBE, HOLD, DONE.
REQ-015 IDLE: start=1 -> SHIFT, block index=0, bit counter=0; start outside IDLE SHALL be ignored.
REQ-016 SHIFT: cfg_ready=1; transfer when cfg_valid&cfg_ready; shift register <= {sr[MEM_SIZE-2:0], cfg_bit}.
REQ-017 SHIFT: after MEM_SIZE-th transfer -> SETUP next cycle; cfg_valid low stalls counter and register.
REQ-018 SETUP: one cycle, config_in = shift register, comb_set all zero.
REQ-019 STROBE: one cycle, comb_set[index]=1, all other bits 0, config_in unchanged.
REQ-020 HOLD: one cycle, comb_set zero, config_in unchanged; index<NUM_BLOCKS-1 -> index+1, SHIFT; else -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 cfg_ready SHALL be 1 only in SHIFT; transfers offered in any other state SHALL be dropped.
REQ-023 config_in SHALL change only on SHIFT transfers, never while comb_set nonzero or in SETUP/HOLD.
REQ-024 comb_set SHALL be registered, glitch-free, at most one bit set in any cycle.
REQ-025 busy SHALL be 1 in SHIFT, SETUP, STROBE, HOLD, DONE; 0 in IDLE.
REQ-026 Minimum pass latency with cfg_valid held high SHALL be NUM_BLOCKS*(MEM_SIZE+3)+1 cycles from start to done.
REQ-027 Bit counter SHALL be $clog2(MEM_SIZE+1) bits wide and SHALL never wrap.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, index=0, counter=0, shift register=0.
REQ-029 During and after reset: cfg_ready=0, comb_set=0, busy=0, done=0, config_in=0.
REQ-030 rst mid-pass (including STROBE) SHALL drop comb_set the following cycle; blocks already written keep contents.
REQ-031 rst SHALL take priority over start in the same cycle.

Structure
REQ-032 State encoding enum and state-count constants SHALL live in shared package clb_cfg_pkg.
REQ-033 Shift register plus bit counter SHALL be sub-module cfg_shift_reg; FSM and comb_set decode in top.

Verification
REQ-034 NUM_BLOCKS=2, MEM_SIZE=16, cfg_valid=1, stream 0xA5C3 then 0x1234 -> comb_set[0] pulse with config_in=0xA5C3, comb_set[1] pulse with 0x1234, done at cycle 39.
REQ-035 Stall: deassert cfg_valid 5 cycles mid-word -> word captured intact, done delayed exactly 5 cycles.
REQ-036 rst asserted during STROBE of block 1 -> comb_set=0 next cycle, busy=0, later start completes a normal pass.
REQ-037 start pulsed while busy and cfg_valid driven in SETUP/STROBE/HOLD -> no restart, stray bits ignored, output words unchanged.
REQ-038 Assertion check every cycle: $onehot0(comb_set); config_in stable from SETUP through HOLD; cfg_ready implies SHIFT.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
// Shared state encoding and state-count constants for the block config loader.
package clb_cfg_pkg;

    localparam int unsigned CLB_NUM_STATES = 6;
    localparam int unsigned CLB_STATE_W    = $clog2(CLB_NUM_STATES);

    typedef enum logic [CLB_STATE_W-1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } clb_state_e;

endpackage

// File: rtl/block_config_loader_if.sv
// Serial configuration stream: one bit per transfer, valid/ready handshake.
interface block_config_loader_if;

    logic cfg_bit;
    logic cfg_valid;
    logic cfg_ready;

    modport master (output cfg_bit, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_bit, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/cfg_shift_reg.sv
// Serial-to-parallel shift register with a saturating bit counter.
// The counter restarts whenever clr is high, so each block begins at zero.
module cfg_shift_reg #(
    parameter int MEM_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                shift_en,
    input  logic                bit_in,
    output logic [MEM_SIZE-1:0] sr,
    output logic                last
);

    localparam int CNT_W = $clog2(MEM_SIZE + 1);

    logic [MEM_SIZE-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Shift in one bit per transfer; counter holds at MEM_SIZE instead of wrapping.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (shift_en && (cnt_q < CNT_W'(MEM_SIZE))) begin
            sr_d  = {sr_q[MEM_SIZE-2:0], bit_in};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Register shift contents and bit count; reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr   = sr_q;
    assign last = shift_en && !clr && (cnt_q == CNT_W'(MEM_SIZE - 1));

endmodule

// File: rtl/block_config_loader.sv
// Sequences a serial config stream into NUM_BLOCKS latch blocks: shift a word,
// present it, pulse that block's latch enable, then move to the next block.
// config_in is the shift register itself, so it only moves on accepted bits.
module block_config_loader
    import clb_cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int MEM_SIZE   = 16,
    parameter int IDX_BITS   = $clog2(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    block_config_loader_if.slave  cfg,
    output logic [MEM_SIZE-1:0]   config_in,
    output logic [NUM_BLOCKS-1:0] comb_set,
    output logic                  busy,
    output logic                  done
);

    clb_state_e            state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [NUM_BLOCKS-1:0] comb_set_q, comb_set_d;
    logic                  ready;
    logic                  shift_en;
    logic                  word_last;

    assign ready    = (state_q == ST_SHIFT);
    assign shift_en = cfg.cfg_valid && ready;

    cfg_shift_reg #(
        .MEM_SIZE (MEM_SIZE)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (!ready),
        .shift_en (shift_en),
        .bit_in   (cfg.cfg_bit),
        .sr       (config_in),
        .last     (word_last)
    );

    // Next-state, block index and one-hot latch enable for the following cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        comb_set_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    idx_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (word_last) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                for (int i = 0; i < NUM_BLOCKS; i++) begin
                    if (idx_q == IDX_BITS'(i)) begin
                        comb_set_d[i] = 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (idx_q == IDX_BITS'(NUM_BLOCKS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_BITS'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, index and latch-enable registers; reset drops comb_set immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            comb_set_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            comb_set_q <= comb_set_d;
        end
    end

    assign cfg.cfg_ready = ready;
    assign comb_set      = comb_set_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_block_config_loader.sv
// Directed bench for block_config_loader with two 16-bit blocks.
module tb_block_config_loader;

    localparam int NB = 2;
    localparam int MS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MS-1:0] config_in;
    logic [NB-1:0] comb_set;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    block_config_loader_if cfg_bus ();

    block_config_loader #(
        .NUM_BLOCKS (NB),
        .MEM_SIZE   (MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg       (cfg_bus),
        .config_in (config_in),
        .comb_set  (comb_set),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants plus a record of every latch strobe.
    logic                 mon_en  = 1'b0;
    logic                 prev_ok = 1'b0;
    logic                 prev_rst;
    logic                 prev_ready;
    logic [MS-1:0]        prev_cfg;
    logic [NB+MS-1:0]     pulses[$];

    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot0", 32'($onehot0(comb_set)), 32'd1);
            chk("ready_only_shift", 32'(cfg_bus.cfg_ready && (!busy || (comb_set != '0))), 32'd0);
            if (prev_ok && !prev_rst && !prev_ready)
                chk("cfg_stable", 32'(config_in), 32'(prev_cfg));
            if (comb_set != '0)
                pulses.push_back({comb_set, config_in});
            prev_ok    = 1'b1;
            prev_rst   = rst;
            prev_ready = cfg_bus.cfg_ready;
            prev_cfg   = config_in;
        end
    end

    task automatic run_pass(input logic [15:0] w0, input logic [15:0] w1,
                            input int stall_at, input int stall_len,
                            input bit stray, input bit stop_at_strobe1,
                            output int cyc);
        int          nb = 0;
        int          st = 0;
        logic [31:0] stream;
        stream = {w0, w1};
        pulses.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            if (done) break;
            if (stop_at_strobe1 && comb_set[1]) break;
            start             = 1'b0;
            cfg_bus.cfg_valid = 1'b0;
            cfg_bus.cfg_bit   = 1'b0;
            if (cfg_bus.cfg_ready) begin
                if (nb == stall_at && st < stall_len) begin
                    st++;
                end else if (nb < 32) begin
                    cfg_bus.cfg_valid = 1'b1;
                    cfg_bus.cfg_bit   = stream[31-nb];
                    nb++;
                end
            end else if (stray && busy) begin
                cfg_bus.cfg_valid = 1'b1;
                cfg_bus.cfg_bit   = 1'b1;
                start             = 1'b1;
            end
            tick();
            cyc++;
        end
        if (cyc >= 200) chk("pass_timeout", 32'(cyc), 32'd0);
        start             = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_bit   = 1'b0;
    endtask

    task automatic check_pulses(input string tag, input logic [15:0] w0, input logic [15:0] w1);
        chk({tag, "_npulse"}, 32'(pulses.size()), 32'd2);
        if (pulses.size() >= 2) begin
            chk({tag, "_blk0"}, 32'(pulses[0]), 32'({2'b01, w0}));
            chk({tag, "_blk1"}, 32'(pulses[1]), 32'({2'b10, w1}));
        end
    endtask

    initial begin
        int cyc;
        rst               = 1'b1;
        start             = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_bit   = 1'b0;
        repeat (3) tick();

        chk("rst_ready",    32'(cfg_bus.cfg_ready), 32'd0);
        chk("rst_comb_set", 32'(comb_set),          32'd0);
        chk("rst_busy",     32'(busy),              32'd0);
        chk("rst_done",     32'(done),              32'd0);
        chk("rst_config",   32'(config_in),         32'd0);
        mon_en = 1'b1;
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Basic pass: two words, valid held high.
        run_pass(16'hA5C3, 16'h1234, -1, 0, 1'b0, 1'b0, cyc);
        chk("basic_latency", 32'(cyc), 32'd39);
        chk("basic_busy_in_done", 32'(busy), 32'd1);
        check_pulses("basic", 16'hA5C3, 16'h1234);
        tick();
        chk("basic_done_one_cycle", 32'(done), 32'd0);
        chk("basic_idle_busy", 32'(busy), 32'd0);
        tick();

        // Five-cycle stall in the middle of block 0.
        run_pass(16'h0F0F, 16'hBEEF, 7, 5, 1'b0, 1'b0, cyc);
        chk("stall_latency", 32'(cyc), 32'd44);
        check_pulses("stall", 16'h0F0F, 16'hBEEF);
        tick();
        tick();

        // Start pulses and stray bits offered while not shifting.
        run_pass(16'h8001, 16'h7FFE, -1, 0, 1'b1, 1'b0, cyc);
        chk("stray_latency", 32'(cyc), 32'd39);
        check_pulses("stray", 16'h8001, 16'h7FFE);
        tick();
        chk("stray_no_restart", 32'(busy), 32'd0);
        tick();

        // Reset while block 1 is being strobed.
        run_pass(16'h5555, 16'hAAAA, -1, 0, 1'b0, 1'b1, cyc);
        chk("strobe1_seen", 32'(comb_set), 32'd2);
        rst = 1'b1;
        tick();
        chk("midrst_comb_set", 32'(comb_set),          32'd0);
        chk("midrst_busy",     32'(busy),              32'd0);
        chk("midrst_ready",    32'(cfg_bus.cfg_ready), 32'd0);
        chk("midrst_config",   32'(config_in),         32'd0);
        if (pulses.size() >= 1)
            chk("midrst_blk0", 32'(pulses[0]), 32'({2'b01, 16'h5555}));
        else
            chk("midrst_blk0_missing", 32'(pulses.size()), 32'd1);
        rst = 1'b0;
        tick();

        // Normal pass after the aborted one.
        run_pass(16'hC0DE, 16'h600D, -1, 0, 1'b0, 1'b0, cyc);
        chk("post_rst_latency", 32'(cyc), 32'd39);
        check_pulses("post_rst", 16'hC0DE, 16'h600D);
        tick();
        tick();
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
